// File: rtl/fetch_queue.sv
// fetch_queue: prefetching 6502 instruction fetcher that assembles opcode+operand
// packets and buffers them in a DEPTH-entry FIFO with synchronous redirect/flush.
module fetch_queue #(
    parameter int ADDR_WIDTH = 16,
    parameter int REG_WIDTH = 8,
    parameter int DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = 16'h8000
) (
    input  logic                         phi1,
    input  logic                         reset,
    output logic [ADDR_WIDTH-1:0]        mem_addr,
    output logic                         mem_rd,
    input  logic [REG_WIDTH-1:0]         mem_data,
    input  logic                         redirect,
    input  logic [ADDR_WIDTH-1:0]        redirect_pc,
    output logic                         instr_valid,
    input  logic                         instr_ready,
    output logic [REG_WIDTH-1:0]         instr_opcode,
    output logic [REG_WIDTH-1:0]         instr_op_lo,
    output logic [REG_WIDTH-1:0]         instr_op_hi,
    output logic [1:0]                   instr_len,
    output logic [ADDR_WIDTH-1:0]        instr_pc,
    output logic [ADDR_WIDTH-1:0]        fetch_pc,
    output logic [$clog2(DEPTH):0]       count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    typedef enum logic [1:0] {FETCH_OP, FETCH_B1, FETCH_B2} state_t;

    state_t state_q, state_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d, pc_q, pc_d, push_pc;
    logic [REG_WIDTH-1:0] op_q, op_d, lo_q, lo_d, push_op, push_lo, push_hi;
    logic [1:0] len_q, len_d, dec_len, push_len;
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    logic cap, push, pop;
    logic [REG_WIDTH-1:0] f_op_q [DEPTH];
    logic [REG_WIDTH-1:0] f_lo_q [DEPTH];
    logic [REG_WIDTH-1:0] f_hi_q [DEPTH];
    logic [1:0] f_len_q [DEPTH];
    logic [ADDR_WIDTH-1:0] f_pc_q [DEPTH];

    function automatic logic [1:0] decode_len(input logic [7:0] op);
        logic [2:0] bbb;
        bbb = op[4:2];
        if (op[3:0] == 4'h8 || op[3:0] == 4'hA || op == 8'h00 || op == 8'h40 || op == 8'h60 || op[1:0] == 2'b11)
            return 2'd1;
        if (op == 8'h20 || bbb == 3'b011 || bbb == 3'b110 || bbb == 3'b111)
            return 2'd3;
        return 2'd2;
    endfunction

    always_ff @(posedge phi1) begin
        if (reset) begin
            state_q <= FETCH_OP;
            fetch_pc_q <= RESET_PC;
            wr_q <= '0;
            rd_q <= '0;
            count_q <= '0;
            op_q <= '0;
            lo_q <= '0;
            len_q <= '0;
            pc_q <= '0;
        end else begin
            state_q <= state_d;
            fetch_pc_q <= fetch_pc_d;
            wr_q <= wr_d;
            rd_q <= rd_d;
            count_q <= count_d;
            op_q <= op_d;
            lo_q <= lo_d;
            len_q <= len_d;
            pc_q <= pc_d;
        end
    end

    always_ff @(posedge phi1) begin
        if (push) begin
            f_op_q[wr_q] <= push_op;
            f_lo_q[wr_q] <= push_lo;
            f_hi_q[wr_q] <= push_hi;
            f_len_q[wr_q] <= push_len;
            f_pc_q[wr_q] <= push_pc;
        end
    end

    always_comb begin
        state_d = redirect ? FETCH_OP :
                  !cap ? state_q :
                  state_q == FETCH_OP ? (dec_len == 2'd1 ? FETCH_OP : FETCH_B1) :
                  (state_q == FETCH_B1 && len_q == 2'd3) ? FETCH_B2 : FETCH_OP;
    end

    // An opcode is only fetched when a whole slot is free, so operand fetch never stalls.
    always_comb begin
        mem_rd = !reset && (state_q != FETCH_OP || count_q != CW'(DEPTH));
        cap = mem_rd && !redirect;
        dec_len = decode_len(mem_data[7:0]);
        push = cap && ((state_q == FETCH_OP && dec_len == 2'd1) || (state_q == FETCH_B1 && len_q == 2'd2) || state_q == FETCH_B2);
        pop = instr_valid && instr_ready && !redirect;
        push_op = state_q == FETCH_OP ? mem_data : op_q;
        push_len = state_q == FETCH_OP ? dec_len : len_q;
        push_pc = state_q == FETCH_OP ? fetch_pc_q : pc_q;
        push_lo = state_q == FETCH_OP ? '0 : state_q == FETCH_B1 ? mem_data : lo_q;
        push_hi = state_q == FETCH_B2 ? mem_data : '0;
    end

    always_comb begin
        op_d = (cap && state_q == FETCH_OP) ? mem_data : op_q;
        len_d = (cap && state_q == FETCH_OP) ? dec_len : len_q;
        pc_d = (cap && state_q == FETCH_OP) ? fetch_pc_q : pc_q;
        lo_d = (cap && state_q == FETCH_B1) ? mem_data : lo_q;
        fetch_pc_d = redirect ? redirect_pc : fetch_pc_q + ADDR_WIDTH'(cap);
        wr_d = redirect ? '0 : wr_q + PW'(push);
        rd_d = redirect ? '0 : rd_q + PW'(pop);
        count_d = redirect ? '0 : count_q + CW'(push) - CW'(pop);
    end

    always_comb begin
        instr_valid = count_q != '0;
        instr_opcode = instr_valid ? f_op_q[rd_q] : '0;
        instr_op_lo = instr_valid ? f_lo_q[rd_q] : '0;
        instr_op_hi = instr_valid ? f_hi_q[rd_q] : '0;
        instr_len = instr_valid ? f_len_q[rd_q] : '0;
        instr_pc = instr_valid ? f_pc_q[rd_q] : '0;
        mem_addr = fetch_pc_q;
        fetch_pc = fetch_pc_q;
        count = count_q;
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed vectors for fetch_queue against a byte-array memory model.
module tb_fetch_queue;
    logic phi1 = 1'b0, reset = 1'b1, redirect = 1'b0, instr_ready = 1'b0;
    logic mem_rd, instr_valid;
    logic [15:0] mem_addr, redirect_pc = 16'h0, instr_pc, fetch_pc;
    logic [7:0] mem_data, instr_opcode, instr_op_lo, instr_op_hi;
    logic [1:0] instr_len;
    logic [2:0] count;
    logic [7:0] mem [65536];
    logic [41:0] got [$];
    int vectors = 0, miscompares = 0;

    always #5 phi1 = ~phi1;
    assign mem_data = mem[mem_addr];

    fetch_queue dut (
        .phi1(phi1), .reset(reset), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
        .redirect(redirect), .redirect_pc(redirect_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instr_opcode(instr_opcode), .instr_op_lo(instr_op_lo),
        .instr_op_hi(instr_op_hi), .instr_len(instr_len), .instr_pc(instr_pc),
        .fetch_pc(fetch_pc), .count(count)
    );

    always @(posedge phi1)
        if (!reset && !redirect && instr_valid && instr_ready)
            got.push_back({instr_opcode, instr_op_lo, instr_op_hi, instr_len, instr_pc});

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge phi1);
            #1;
        end
    endtask

    task automatic jump(input logic [15:0] pc);
        redirect = 1'b1;
        redirect_pc = pc;
        tick();
        redirect = 1'b0;
    endtask

    function automatic logic [41:0] pkt(input logic [7:0] op, lo, hi, input logic [1:0] len, input logic [15:0] pc);
        return {op, lo, hi, len, pc};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int bad;
        for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
        mem[16'h8001] = 8'hA9; mem[16'h8002] = 8'h05; mem[16'h8003] = 8'hAD;
        mem[16'h8004] = 8'h34; mem[16'h8005] = 8'h12;
        // reset state and first packets
        instr_ready = 1'b1;
        tick(2);
        check("rst_mem_rd", mem_rd, 0);
        check("rst_count", count, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_fetch_pc", fetch_pc, 16'h8000);
        check("rst_opcode", instr_opcode, 0);
        got.delete();
        reset = 1'b0;
        #1;
        check("rel_valid", instr_valid, 0);
        check("rel_mem_rd", mem_rd, 1);
        tick();
        check("t1_valid", instr_valid, 1);
        check("t1_head", {instr_opcode, instr_op_lo, instr_op_hi, instr_len, instr_pc}, pkt(8'hEA, 0, 0, 1, 16'h8000));
        tick(8);
        check("t1_n", got.size() >= 3, 1);
        check("t1_p0", got[0], pkt(8'hEA, 8'h00, 8'h00, 2'd1, 16'h8000));
        check("t1_p1", got[1], pkt(8'hA9, 8'h05, 8'h00, 2'd2, 16'h8001));
        check("t1_p2", got[2], pkt(8'hAD, 8'h34, 8'h12, 2'd3, 16'h8003));
        // fill to full, single pop admits exactly one more fetch
        for (int i = 16'h8001; i < 16'h8006; i++) mem[i] = 8'hEA;
        instr_ready = 1'b0;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(4);
        check("t2_count", count, 4);
        check("t2_mem_rd", mem_rd, 0);
        check("t2_fetch_pc", fetch_pc, 16'h8004);
        tick(2);
        check("t2_hold_count", count, 4);
        check("t2_hold_pc", fetch_pc, 16'h8004);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check("t2_pop_count", count, 3);
        check("t2_pop_rd", mem_rd, 1);
        tick();
        check("t2_refill_count", count, 4);
        check("t2_refill_pc", fetch_pc, 16'h8005);
        tick(2);
        check("t2_stall_pc", fetch_pc, 16'h8005);
        // redirect while assembling 4C
        mem[16'h8010] = 8'h4C; mem[16'h8011] = 8'h00; mem[16'h8012] = 8'h90;
        mem[16'hC000] = 8'hA9; mem[16'hC001] = 8'h77;
        instr_ready = 1'b1;
        jump(16'h8010);
        got.delete();
        tick();
        check("t3_b1_pc", fetch_pc, 16'h8011);
        redirect = 1'b1;
        redirect_pc = 16'hC000;
        #1;
        check("t3_redir_rd", mem_rd, 1);
        tick();
        redirect = 1'b0;
        check("t3_count", count, 0);
        check("t3_valid", instr_valid, 0);
        check("t3_addr", mem_addr, 16'hC000);
        tick(6);
        check("t3_n", got.size() >= 1, 1);
        check("t3_p0", got[0], pkt(8'hA9, 8'h77, 8'h00, 2'd2, 16'hC000));
        bad = 0;
        foreach (got[i]) if (got[i][41:34] == 8'h4C) bad++;
        check("t3_no4c", bad, 0);
        // operands across address wrap
        instr_ready = 1'b0;
        mem[16'hFFFE] = 8'h20; mem[16'hFFFF] = 8'h00; mem[16'h0000] = 8'h80;
        jump(16'hFFFE);
        tick(3);
        check("t4_head", {instr_opcode, instr_op_lo, instr_op_hi, instr_len, instr_pc}, pkt(8'h20, 8'h00, 8'h80, 3, 16'hFFFE));
        check("t4_fetch_pc", fetch_pc, 16'h0001);
        check("t4_count", count, 1);
        // simultaneous pop and push
        mem[16'h9000] = 8'hEA; mem[16'h9001] = 8'h18; mem[16'h9002] = 8'h38; mem[16'h9003] = 8'h58;
        jump(16'h9000);
        tick(2);
        check("t5_count0", count, 2);
        check("t5_head0", instr_opcode, 8'hEA);
        instr_ready = 1'b1;
        tick();
        check("t5_count1", count, 2);
        check("t5_head1", {instr_opcode, instr_pc}, {8'h18, 16'h9001});
        tick();
        instr_ready = 1'b0;
        check("t5_count2", count, 2);
        check("t5_head2", {instr_opcode, instr_pc}, {8'h38, 16'h9002});
        // reset beats redirect mid-instruction
        jump(16'h8010);
        tick();
        reset = 1'b1;
        redirect = 1'b1;
        redirect_pc = 16'hC000;
        tick();
        check("t6_fetch_pc", fetch_pc, 16'h8000);
        check("t6_count", count, 0);
        check("t6_mem_rd", mem_rd, 0);
        check("t6_valid", instr_valid, 0);
        reset = 1'b0;
        redirect = 1'b0;
        tick();
        check("t6_head", {instr_opcode, instr_len, instr_pc}, {8'hEA, 2'd1, 16'h8000});
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
